// File: rtl/k052109_pkg.sv
// Shared types and constants for the k052109 CPU-port bus master.
// Holds the bus FSM state encoding, the chip-select codes carried by a
// command, the latched command record, and the select decoder used to
// drive the active-low VCS/CRCS pins.
package k052109_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_E = 2'd1,
        ADDR   = 2'd2,
        DATA   = 2'd3
    } bus_state_t;

    localparam logic [1:0] CS_NONE = 2'b00;
    localparam logic [1:0] CS_VRAM = 2'b01;
    localparam logic [1:0] CS_CRAM = 2'b10;

    typedef struct packed {
        logic        write;
        logic [1:0]  sel;
        logic        rmrd;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } bus_cmd_t;

    // Returns {CRCS, VCS}, both active-low. The reserved code 11 selects nothing.
    function automatic logic [1:0] cs_decode(input logic [1:0] sel);
        case (sel)
            CS_VRAM: cs_decode = 2'b10;
            CS_CRAM: cs_decode = 2'b01;
            CS_NONE: cs_decode = 2'b11;
            default: cs_decode = 2'b11;
        endcase
    endfunction

endpackage

// File: rtl/k052109_sync_bit.sv
// Multi-flop synchronizer for one active-low chip output.
// Ports:
//   clk_i   - sampling clock
//   rst_n_i - asynchronous active-low reset; all stages preset to 1
//             so the synchronized level reads "inactive" out of reset
//   d_i     - asynchronous input
//   q_o     - synchronized output, SYNC_STAGES cycles behind d_i
module k052109_sync_bit #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/k052109_cpu_bus_master.sv
// 6809-style CPU bus initiator for the k052109 CPU port.
// Converts a valid/ready command stream into bus cycles aligned to the
// chip's E/Q phase clocks and returns a one-cycle response per cycle.
// Ports:
//   M24, RES                - master clock, async active-low reset
//   PE, PQ                  - E/Q phase clocks (synchronous to M24)
//   RST, NMI, IRQ, FIRQ     - chip status/interrupt outputs (async, active-low)
//   cmd_*                   - command channel (valid/ready handshake)
//   rsp_valid, rsp_rdata    - completion pulse and captured read data
//   AB, NRD, VCS, CRCS, RMRD, DB_OUT, DB_OE, DB_IN - CPU bus pins
//   irq_n_s, firq_n_s       - synchronized interrupt levels
//   nmi_pend, nmi_ack       - latched NMI edge and its clear
module k052109_cpu_bus_master
    import k052109_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        M24,
    input  logic        RES,
    input  logic        PE,
    input  logic        PQ,
    input  logic        RST,
    input  logic        NMI,
    input  logic        IRQ,
    input  logic        FIRQ,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_sel,
    input  logic        cmd_rmrd,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] AB,
    output logic        NRD,
    output logic        VCS,
    output logic        CRCS,
    output logic        RMRD,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    input  logic [7:0]  DB_IN,
    output logic        irq_n_s,
    output logic        firq_n_s,
    output logic        nmi_pend,
    input  logic        nmi_ack
);

    logic rst_s, nmi_s;

    k052109_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rst  (.clk_i(M24), .rst_n_i(RES), .d_i(RST),  .q_o(rst_s));
    k052109_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_nmi  (.clk_i(M24), .rst_n_i(RES), .d_i(NMI),  .q_o(nmi_s));
    k052109_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_irq  (.clk_i(M24), .rst_n_i(RES), .d_i(IRQ),  .q_o(irq_n_s));
    k052109_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_firq (.clk_i(M24), .rst_n_i(RES), .d_i(FIRQ), .q_o(firq_n_s));

    bus_state_t  state_q, state_d;
    bus_cmd_t    cur_q, cur_d, hold_q, hold_d, cmd_in, drv_cmd;
    logic        hold_full_q, hold_full_d;
    logic        run_q, pe_q, pq_q, nmi_s_q;
    logic        nmi_pend_q, nmi_pend_d;
    logic [15:0] ab_q, ab_d;
    logic        nrd_q, nrd_d, vcs_q, vcs_d, crcs_q, crcs_d, rmrd_q, rmrd_d;
    logic [7:0]  db_out_q, db_out_d, rdata_q, rdata_d;
    logic        db_oe_q, db_oe_d, rsp_valid_q, rsp_valid_d;
    logic        e_fall, q_rise, accept, drv_en;

    assign cmd_in = '{write: cmd_write, sel: cmd_sel, rmrd: cmd_rmrd,
                      addr: cmd_addr, wdata: cmd_wdata};

    assign e_fall = pe_q & ~PE;
    assign q_rise = ~pq_q & PQ;

    // State register
    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = WAIT_E;
            WAIT_E:  if (e_fall) state_d = ADDR;
            ADDR:    if (q_rise) state_d = DATA;
            DATA:    if (e_fall) state_d = (hold_full_q || accept) ? ADDR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        // run_q keeps cmd_ready low for the first cycle out of reset.
        cmd_ready   = run_q & rst_s &
                      ((state_q == IDLE) || (state_q == DATA && !hold_full_q));
        accept      = cmd_valid & cmd_ready;
        cur_d       = cur_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ab_d        = ab_q;
        nrd_d       = nrd_q;
        vcs_d       = vcs_q;
        crcs_d      = crcs_q;
        rmrd_d      = rmrd_q;
        db_out_d    = db_out_q;
        db_oe_d     = db_oe_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        drv_en      = 1'b0;
        drv_cmd     = cur_q;
        case (state_q)
            IDLE: begin
                if (accept) cur_d = cmd_in;
            end
            WAIT_E: begin
                drv_en = e_fall;
            end
            ADDR: begin
                if (q_rise && cur_q.write) begin
                    db_out_d = cur_q.wdata;
                    db_oe_d  = 1'b1;
                end
            end
            DATA: begin
                // A command arriving on the closing edge with an empty
                // holding register bypasses it and starts immediately.
                if (accept && !e_fall) begin
                    hold_d      = cmd_in;
                    hold_full_d = 1'b1;
                end
                if (e_fall) begin
                    rsp_valid_d = 1'b1;
                    if (!cur_q.write) rdata_d = DB_IN;
                    nrd_d   = 1'b1;
                    vcs_d   = 1'b1;
                    crcs_d  = 1'b1;
                    rmrd_d  = 1'b0;
                    db_oe_d = 1'b0;
                    if (hold_full_q || accept) begin
                        drv_cmd     = hold_full_q ? hold_q : cmd_in;
                        cur_d       = drv_cmd;
                        hold_full_d = 1'b0;
                        drv_en      = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (drv_en) begin
            ab_d            = drv_cmd.addr;
            nrd_d           = ~drv_cmd.write;
            {crcs_d, vcs_d} = cs_decode(drv_cmd.sel);
            rmrd_d          = drv_cmd.rmrd;
        end
        // A new synced NMI edge takes priority over a same-cycle ack.
        nmi_pend_d = (nmi_s_q & ~nmi_s) ? 1'b1 : (nmi_ack ? 1'b0 : nmi_pend_q);
    end

    // Datapath and pin registers
    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            cur_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            run_q       <= 1'b0;
            pe_q        <= 1'b0;
            pq_q        <= 1'b0;
            nmi_s_q     <= 1'b1;
            nmi_pend_q  <= 1'b0;
            ab_q        <= '0;
            nrd_q       <= 1'b1;
            vcs_q       <= 1'b1;
            crcs_q      <= 1'b1;
            rmrd_q      <= 1'b0;
            db_out_q    <= '0;
            db_oe_q     <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            run_q       <= 1'b1;
            pe_q        <= PE;
            pq_q        <= PQ;
            nmi_s_q     <= nmi_s;
            nmi_pend_q  <= nmi_pend_d;
            ab_q        <= ab_d;
            nrd_q       <= nrd_d;
            vcs_q       <= vcs_d;
            crcs_q      <= crcs_d;
            rmrd_q      <= rmrd_d;
            db_out_q    <= db_out_d;
            db_oe_q     <= db_oe_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign AB        = ab_q;
    assign NRD       = nrd_q;
    assign VCS       = vcs_q;
    assign CRCS      = crcs_q;
    assign RMRD      = rmrd_q;
    assign DB_OUT    = db_out_q;
    assign DB_OE     = db_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign nmi_pend  = nmi_pend_q;

endmodule

// File: tb/tb_k052109_cpu_bus_master.sv
module tb_k052109_cpu_bus_master;

    logic        M24 = 1'b0;
    logic        RES = 1'b1;
    logic        PE = 1'b0, PQ = 1'b0;
    logic        RST = 1'b1, NMI = 1'b1, IRQ = 1'b1, FIRQ = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_rmrd = 1'b0;
    logic [1:0]  cmd_sel = 2'b00;
    logic [15:0] cmd_addr = 16'h0;
    logic [7:0]  cmd_wdata = 8'h0, DB_IN = 8'h0;
    logic        nmi_ack = 1'b0;
    logic        cmd_ready, rsp_valid, NRD, VCS, CRCS, RMRD, DB_OE;
    logic        irq_n_s, firq_n_s, nmi_pend;
    logic [7:0]  rsp_rdata, DB_OUT;
    logic [15:0] AB;

    int checks = 0;
    int failures = 0;
    logic [2:0] ph = 3'd7;

    k052109_cpu_bus_master #(.SYNC_STAGES(2)) dut (
        .M24(M24), .RES(RES), .PE(PE), .PQ(PQ), .RST(RST),
        .NMI(NMI), .IRQ(IRQ), .FIRQ(FIRQ),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_sel(cmd_sel), .cmd_rmrd(cmd_rmrd), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .AB(AB), .NRD(NRD), .VCS(VCS), .CRCS(CRCS), .RMRD(RMRD),
        .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DB_IN(DB_IN),
        .irq_n_s(irq_n_s), .firq_n_s(firq_n_s),
        .nmi_pend(nmi_pend), .nmi_ack(nmi_ack)
    );

    always #5 M24 = ~M24;

    // E period = 8 M24: Q high on phases 2..5, E high on phases 4..7.
    always @(posedge M24) begin
        #3;
        ph = ph + 3'd1;
        PE = (ph >= 3'd4);
        PQ = (ph >= 3'd2) && (ph <= 3'd5);
    end

    typedef struct {
        logic        w;
        logic [1:0]  sel;
        logic        rm;
        logic [15:0] addr;
        logic [7:0]  wd;
        logic [7:0]  dbin;
        logic        e_vcs;
        logic        e_crcs;
        logic        e_rmrd;
        logic        e_nrd;
        logic        e_oe;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge M24);
        #5;
    endtask

    task automatic step_to(input logic [2:0] p);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ph != p && n < 20);
        if (ph != p) chk("phase_timeout", 32'(ph), 32'(p));
    endtask

    task automatic set_cmd(input logic w, input logic [1:0] s, input logic rm,
                           input logic [15:0] a, input logic [7:0] d);
        cmd_write = w; cmd_sel = s; cmd_rmrd = rm; cmd_addr = a; cmd_wdata = d;
    endtask

    int acc, vcs_low, npulse, act, n;
    int pt[3];
    logic [15:0] pab[3];
    logic took;

    initial begin
        //        w     sel    rm    addr      wd     dbin   vcs   crcs  rmrd  nrd   oe    rdata
        vt[0] = '{1'b1, 2'b01, 1'b0, 16'h1234, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
        vt[1] = '{1'b0, 2'b10, 1'b0, 16'h0800, 8'h00, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3};
        vt[2] = '{1'b0, 2'b00, 1'b1, 16'h2000, 8'h00, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h7E};
        vt[3] = '{1'b1, 2'b11, 1'b0, 16'h3C5A, 8'hA5, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7E};

        // Reset values
        #2 RES = 1'b0;
        #1;
        chk("rst_ab", 32'(AB), 0);
        chk("rst_nrd", 32'(NRD), 1);
        chk("rst_vcs", 32'(VCS), 1);
        chk("rst_crcs", 32'(CRCS), 1);
        chk("rst_rmrd", 32'(RMRD), 0);
        chk("rst_dbout", 32'(DB_OUT), 0);
        chk("rst_dboe", 32'(DB_OE), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_rsp", 32'(rsp_valid), 0);
        chk("rst_rdata", 32'(rsp_rdata), 0);
        chk("rst_nmi", 32'(nmi_pend), 0);
        chk("rst_irq", 32'(irq_n_s), 1);
        tick(); tick(); tick();
        RES = 1'b1;
        tick();

        // Single transactions from the table
        for (int i = 0; i < 4; i++) begin
            step_to(3'd2);
            set_cmd(vt[i].w, vt[i].sel, vt[i].rm, vt[i].addr, vt[i].wd);
            DB_IN = vt[i].dbin;
            cmd_valid = 1'b1;
            chk($sformatf("v%0d_ready", i), 32'(cmd_ready), 1);
            tick();
            cmd_valid = 1'b0;
            step_to(3'd0);
            chk($sformatf("v%0d_pre_vcs", i), 32'(VCS), 1);
            chk($sformatf("v%0d_pre_crcs", i), 32'(CRCS), 1);
            tick();
            chk($sformatf("v%0d_ab", i), 32'(AB), 32'(vt[i].addr));
            chk($sformatf("v%0d_nrd", i), 32'(NRD), 32'(vt[i].e_nrd));
            chk($sformatf("v%0d_vcs", i), 32'(VCS), 32'(vt[i].e_vcs));
            chk($sformatf("v%0d_crcs", i), 32'(CRCS), 32'(vt[i].e_crcs));
            chk($sformatf("v%0d_rmrd", i), 32'(RMRD), 32'(vt[i].e_rmrd));
            chk($sformatf("v%0d_oe_ph1", i), 32'(DB_OE), 0);
            tick();
            chk($sformatf("v%0d_oe_ph2", i), 32'(DB_OE), 0);
            tick();
            chk($sformatf("v%0d_oe_ph3", i), 32'(DB_OE), 32'(vt[i].e_oe));
            if (vt[i].e_oe) chk($sformatf("v%0d_dbout", i), 32'(DB_OUT), 32'(vt[i].wd));
            step_to(3'd0);
            chk($sformatf("v%0d_rsp_early", i), 32'(rsp_valid), 0);
            chk($sformatf("v%0d_rmrd_hold", i), 32'(RMRD), 32'(vt[i].e_rmrd));
            chk($sformatf("v%0d_vcs_hold", i), 32'(VCS), 32'(vt[i].e_vcs));
            tick();
            chk($sformatf("v%0d_rsp", i), 32'(rsp_valid), 1);
            chk($sformatf("v%0d_rdata", i), 32'(rsp_rdata), 32'(vt[i].e_rdata));
            chk($sformatf("v%0d_end_vcs", i), 32'(VCS), 1);
            chk($sformatf("v%0d_end_crcs", i), 32'(CRCS), 1);
            chk($sformatf("v%0d_end_rmrd", i), 32'(RMRD), 0);
            chk($sformatf("v%0d_end_nrd", i), 32'(NRD), 1);
            chk($sformatf("v%0d_end_oe", i), 32'(DB_OE), 0);
            chk($sformatf("v%0d_end_ab", i), 32'(AB), 32'(vt[i].addr));
            tick();
            chk($sformatf("v%0d_rsp_pulse", i), 32'(rsp_valid), 0);
            chk($sformatf("v%0d_rdata_held", i), 32'(rsp_rdata), 32'(vt[i].e_rdata));
        end

        // Back-to-back: three writes with cmd_valid held
        step_to(3'd2);
        acc = 0; vcs_low = 0; npulse = 0;
        set_cmd(1'b1, 2'b01, 1'b0, 16'h0100, 8'h10);
        cmd_valid = 1'b1;
        for (int c = 0; c < 48; c++) begin
            took = cmd_valid & cmd_ready;
            tick();
            if (took) begin
                acc++;
                cmd_addr  = 16'(32'h100 + acc);
                cmd_wdata = 8'(32'h10 + acc);
                if (acc == 3) cmd_valid = 1'b0;
            end
            if (!VCS) vcs_low++;
            if (rsp_valid) begin
                if (npulse < 3) begin
                    pt[npulse]  = c;
                    pab[npulse] = AB;
                end
                npulse++;
            end
        end
        chk("b2b_accepted", 32'(acc), 3);
        chk("b2b_pulses", 32'(npulse), 3);
        chk("b2b_gap01", 32'(pt[1] - pt[0]), 8);
        chk("b2b_gap12", 32'(pt[2] - pt[1]), 8);
        chk("b2b_vcs_low", 32'(vcs_low), 24);
        chk("b2b_ab0", 32'(pab[0]), 'h0101);
        chk("b2b_ab1", 32'(pab[1]), 'h0102);
        chk("b2b_ab2", 32'(pab[2]), 'h0102);

        // RST low blocks acceptance
        step_to(3'd2);
        RST = 1'b0;
        tick(); tick(); tick();
        chk("rstlow_ready", 32'(cmd_ready), 0);
        set_cmd(1'b1, 2'b10, 1'b0, 16'h4444, 8'h44);
        cmd_valid = 1'b1;
        act = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (!VCS || !CRCS || rsp_valid) act++;
        end
        chk("rstlow_no_bus", 32'(act), 0);
        chk("rstlow_ready2", 32'(cmd_ready), 0);
        RST = 1'b1;
        n = 0;
        while (!cmd_ready && n < 8) begin tick(); n++; end
        chk("rsthi_ready", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (CRCS && n < 16) begin tick(); n++; end
        chk("rsthi_crcs", 32'(CRCS), 0);
        n = 0;
        while (!rsp_valid && n < 24) begin tick(); n++; end
        chk("rsthi_rsp", 32'(rsp_valid), 1);

        // RES pulse while in ADDR
        step_to(3'd2);
        set_cmd(1'b1, 2'b01, 1'b0, 16'h5555, 8'h55);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        step_to(3'd1);
        chk("res_pre_vcs", 32'(VCS), 0);
        RES = 1'b0;
        #1;
        chk("res_ab", 32'(AB), 0);
        chk("res_vcs", 32'(VCS), 1);
        chk("res_nrd", 32'(NRD), 1);
        chk("res_oe", 32'(DB_OE), 0);
        chk("res_ready", 32'(cmd_ready), 0);
        tick();
        RES = 1'b1;
        act = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid || !VCS) act++;
        end
        chk("res_no_rsp", 32'(act), 0);

        // NMI edge, ack, and ack colliding with a new edge
        NMI = 1'b0;
        tick(); tick();
        chk("nmi_early", 32'(nmi_pend), 0);
        tick();
        chk("nmi_set", 32'(nmi_pend), 1);
        NMI = 1'b1;
        nmi_ack = 1'b1;
        tick();
        nmi_ack = 1'b0;
        chk("nmi_ack", 32'(nmi_pend), 0);
        tick(); tick(); tick();
        NMI = 1'b0;
        tick(); tick();
        nmi_ack = 1'b1;
        tick();
        nmi_ack = 1'b0;
        chk("nmi_set_wins", 32'(nmi_pend), 1);
        NMI = 1'b1;

        // IRQ/FIRQ level pass-through
        IRQ = 1'b0;
        tick(); tick(); tick();
        chk("irq_low", 32'(irq_n_s), 0);
        chk("firq_high", 32'(firq_n_s), 1);
        IRQ = 1'b1;
        FIRQ = 1'b0;
        tick(); tick(); tick();
        chk("irq_high", 32'(irq_n_s), 1);
        chk("firq_low", 32'(firq_n_s), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
